// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus IF/ID pipeline register for a 32-bit MIPS
// pipeline. Owns the fetch PC, requests words from instruction memory, and
// presents {instruction, pc_plus4, if_valid} to Decode. A one-entry skid buffer
// captures a word that returns while Decode is stalled, so the memory response
// is never lost and the PC can keep advancing by one word.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   : MIPS branch-delay-slot semantics. A redirect is recorded as a
//               pending target; the next word accepted from memory (the delay
//               slot) still enters IF/ID, and only then does the PC jump.
//   undefined : a redirect squashes IF/ID and the skid and jumps immediately.
//
// Parameters:
//   RESET_PC   - PC value after reset
//   NOP_INSTR  - encoding driven into IF/ID on bubble/flush
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request valid
//   imem_addr    out  word-aligned fetch address
//   imem_rdata   in   instruction word, valid when imem_ready=1
//   imem_ready   in   memory returns imem_rdata for imem_addr this cycle
//   stall        in   hazard unit: hold IF/ID and PC
//   redirect     in   taken branch/jump
//   redirect_pc  in   redirect target, bits [1:0] ignored
//   instruction  out  IF/ID instruction
//   pc_plus4     out  IF/ID PC+4 of that instruction
//   if_valid     out  IF/ID holds a real instruction
//   pc           out  current fetch PC
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic [31:0] pc
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  // Registered state
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;

  // Next-state values
  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_plus4_nxt;
  logic        w_valid_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] w_skid_pc4_nxt;

  // Helpers
  logic [31:0] w_pc4;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_pc_adv;

`ifdef DELAY_SLOT_EN
  logic        r_pend;
  logic [31:0] r_pend_pc;
  logic        w_pend_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic        w_have_tgt;
  logic [31:0] w_tgt;
`endif

  // Sequential wrap is intentional: 32'hFFFF_FFFC + 4 becomes 0.
  assign w_pc4       = r_pc + 32'd4;
  assign w_redir_tgt = {redirect_pc[31:2], 2'b00};

`ifdef DELAY_SLOT_EN
  // A redirect arriving in the same cycle as the delay-slot word takes effect
  // immediately after that word; a newer redirect overrides a pending one.
  assign w_have_tgt = redirect | r_pend;
  assign w_tgt      = redirect ? w_redir_tgt : r_pend_pc;
  assign w_pc_adv   = w_have_tgt ? w_tgt : w_pc4;
`else
  assign w_pc_adv   = w_pc4;
`endif

  // Next-state and IF/ID update logic
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_pc_plus4_nxt   = r_pc_plus4;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
`ifdef DELAY_SLOT_EN
    w_pend_nxt       = r_pend;
    w_pend_pc_nxt    = r_pend_pc;
`endif

    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          // Word accepted: PC advances whether it lands in IF/ID or the skid.
          w_pc_nxt = w_pc_adv;
`ifdef DELAY_SLOT_EN
          w_pend_nxt = 1'b0;
`endif
          if (stall) begin
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc4_nxt   = w_pc4;
            w_state_nxt      = S_HOLD;
          end else begin
            w_instr_nxt    = imem_rdata;
            w_pc_plus4_nxt = w_pc4;
            w_valid_nxt    = 1'b1;
          end
        end else begin
          if (stall) begin
            w_valid_nxt = r_valid;
          end else begin
            // Memory wait: insert a bubble, keep pc_plus4 so Decode sees no
            // spurious value.
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (stall) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_instr_nxt    = r_skid_instr;
          w_pc_plus4_nxt = r_skid_pc4;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

`ifdef DELAY_SLOT_EN
    // Record the target when no delay-slot word is consumed this cycle.
    if (redirect && !((r_state == S_FETCH) && imem_ready)) begin
      w_pend_nxt    = 1'b1;
      w_pend_pc_nxt = w_redir_tgt;
    end else begin
      w_pend_pc_nxt = w_pend_pc_nxt;
    end
`else
    // Redirect overrides everything: squash IF/ID, drop skid and any response.
    if (redirect) begin
      w_pc_nxt    = w_redir_tgt;
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_FETCH;
    end else begin
      w_pc_nxt = w_pc_nxt;
    end
`endif
  end

  // State, PC, IF/ID and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_plus4   <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'h0000_0000;
`ifdef DELAY_SLOT_EN
      r_pend       <= 1'b0;
      r_pend_pc    <= 32'h0000_0000;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_pc_plus4   <= w_pc_plus4_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
`ifdef DELAY_SLOT_EN
      r_pend       <= w_pend_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
`endif
    end
  end

  // The request must be low while reset is asserted yet high in the very first
  // cycle after release, before any clock edge has updated state, so it is
  // qualified directly by rst_n.
  assign imem_req    = rst_n & (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign pc_plus4    = r_pc_plus4;
  assign if_valid    = r_valid;

endmodule
